// File: rtl/imem_loader_if.sv
// Byte-stream handshake feeding the instruction memory loader.
// The source drives valid/data and the loader answers with ready.
interface imem_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: framed byte stream -> big-endian words -> imem write port.
// Verifies an XOR checksum and keeps the core in reset until a good load.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    imem_loader_if.slave      in_bus,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    output logic              cpu_rst_n,
    output logic              done,
    output logic              err
);

    localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_WORD,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [7:0]        len_hi;
    logic [15:0]       len;
    logic [1:0]        bidx;
    logic [ADDR_W-1:0] widx;
    logic [23:0]       part;
    logic [7:0]        chk;

    logic              acc;
    logic [15:0]       len_new;
    logic              len_bad;
    logic              last_word;

    assign in_bus.in_ready = (state != S_DONE) && (state != S_ERR);
    assign acc     = in_bus.in_valid && in_bus.in_ready;
    assign len_new = {len_hi, in_bus.in_data};
    assign len_bad = (len_new == 16'd0) || ({1'b0, len_new} > DEPTH);

    // Length was range-checked, so len-1 always fits the word index.
    assign last_word = (bidx == 2'd3) &&
                       (17'(widx) == ({1'b0, len} - 17'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LEN_HI;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_LEN_HI: begin
                if (acc) state_n = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (acc) state_n = len_bad ? S_ERR : S_WORD;
            end
            S_WORD: begin
                if (acc && last_word) state_n = S_CHK;
            end
            S_CHK: begin
                if (acc) begin
                    state_n = (in_bus.in_data == chk) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (reload) state_n = S_LEN_HI;
            end
            default: state_n = S_LEN_HI;
        endcase
    end

    // Status flags follow the next state so they land one cycle after
    // the deciding byte or reload pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_din  <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            len_hi    <= '0;
            len       <= '0;
            bidx      <= '0;
            widx      <= '0;
            part      <= '0;
            chk       <= '0;
        end else begin
            imem_we   <= 1'b0;
            done      <= (state_n == S_DONE);
            err       <= (state_n == S_ERR);
            cpu_rst_n <= (state_n == S_DONE);
            if (acc) begin
                unique case (state)
                    S_LEN_HI: begin
                        len_hi <= in_bus.in_data;
                    end
                    S_LEN_LO: begin
                        len  <= len_new;
                        bidx <= '0;
                        widx <= '0;
                        chk  <= '0;
                    end
                    S_WORD: begin
                        part <= {part[15:0], in_bus.in_data};
                        chk  <= chk ^ in_bus.in_data;
                        bidx <= bidx + 2'd1;
                        if (bidx == 2'd3) begin
                            imem_we   <= 1'b1;
                            imem_addr <= widx;
                            imem_din  <= {part, in_bus.in_data};
                            widx      <= widx + 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
